// File: rtl/sqr.sv
// Iterative unsigned fixed-point squarer using a radix-2 shift-add multiply.
// One partial product per cycle; the result is truncated to the input Q format and saturates on overflow.
module sqr #(
   parameter int WIDTH = 16,
   parameter int FBITS = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             valid,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] sq,
   output logic             ovf
);

   localparam int PW = 2 * WIDTH;
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [PW-1:0]    m;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    acc_next;
   logic [WIDTH-1:0] b;
   logic [IW-1:0]    i;
   logic             prod_ovf;
   logic [WIDTH-1:0] prod_sq;

   // acc_next is the full 2*WIDTH product once the last partial product is added.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      acc_next = acc;
      if (b[0]) begin
         acc_next = acc + m;
      end
      prod_ovf = |acc_next[PW-1:WIDTH+FBITS];
      prod_sq  = prod_ovf ? {WIDTH{1'b1}} : acc_next[WIDTH+FBITS-1:FBITS];
   end

   // NOTE: non-blocking assignments, so every register samples pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         valid <= 1'b0;
         sq    <= '0;
         ovf   <= 1'b0;
         m     <= '0;
         b     <= '0;
         acc   <= '0;
         i     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  valid <= 1'b0;
                  m     <= PW'(x);
                  b     <= x;
                  acc   <= '0;
                  i     <= '0;
               end
            end
            RUN: begin
               acc <= acc_next;
               m   <= m << 1;
               b   <= b >> 1;
               i   <= i + 1'b1;
               if (i == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  valid <= 1'b1;
                  sq    <= prod_sq;
                  ovf   <= prod_ovf;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sqr.sv
// Testbench for sqr: scoreboard queue filled by the driver, drained by a monitor on valid.
// Reference results come from plain integer arithmetic on x*x.
module tb_sqr;

   localparam int W = 16;
   localparam int F = 12;

   logic         clk;
   logic         rst;
   logic         start;
   logic         busy;
   logic         valid;
   logic [W-1:0] x;
   logic [W-1:0] sq;
   logic         ovf;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W:0] exp_q[$];   // {ovf, sq}
   logic prev_valid = 1'b0;

   sqr #(.WIDTH(W), .FBITS(F)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .busy (busy),
      .valid(valid),
      .x    (x),
      .sq   (sq),
      .ovf  (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic check_rel(input string name, input logic [63:0] act, input logic [63:0] bound,
                            input bit want_ge);
      n_cmp++;
      if (want_ge ? (act < bound) : (act > bound)) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected %s 0x%0h", name, act, want_ge ? ">=" : "<=", bound);
      end
   endtask

   // Real-valued x^2 scaled to the Q format, truncated, saturating past the integer range.
   function automatic logic [W:0] model(input logic [W-1:0] xv);
      longint p;
      p = longint'(xv) * longint'(xv);
      if (p >= (longint'(1) << (W + F))) return {1'b1, {W{1'b1}}};
      return {1'b0, W'(p >> F)};
   endfunction

   function automatic longint isqrt(input longint v);
      longint r = 0;
      for (int k = 20; k >= 0; k--) begin
         longint t = r | (longint'(1) << k);
         if (t * t <= v) r = t;
      end
      return r;
   endfunction

   // Monitor: every rising edge of valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got sq=0x%0h ovf=%0b, expected no result", sq, ovf);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("result_sq", sq, e[W-1:0]);
            check("result_ovf", ovf, e[W]);
         end
      end
      prev_valid = valid;
   end

   // Returns at the first negedge where valid is seen (or the budget runs out).
   task automatic wait_valid(input int started_at, input string name);
      int cycles = started_at;
      while (!valid && cycles < W + 20) begin
         @(negedge clk);
         cycles++;
      end
      check(name, cycles, W + 1);
   endtask

   task automatic run_op(input logic [W-1:0] xv);
      @(negedge clk);
      start = 1'b1;
      x     = xv;
      exp_q.push_back(model(xv));
      @(negedge clk);
      start = 1'b0;
      x     = W'($urandom);
      check("valid_cleared", valid, 1'b0);
      check("busy_set", busy, 1'b1);
      wait_valid(1, "latency");
      check("busy_done", busy, 1'b0);
   endtask

   task automatic watch_no_valid(input string name);
      bit seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         seen |= valid;
      end
      check(name, seen, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] a;
      longint       r;
      logic [W-1:0] held;

      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_valid", valid, 1'b0);
      check("reset_sq", sq, '0);
      check("reset_ovf", ovf, 1'b0);
      rst = 1'b0;

      run_op(16'h1000);
      check("sq_1p0", sq, 16'h1000);
      check("ovf_1p0", ovf, 1'b0);
      held = sq;
      repeat (5) @(negedge clk);
      check("valid_held", valid, 1'b1);
      check("sq_held", sq, held);

      run_op(16'h1800);
      check("sq_1p5", sq, 16'h2400);
      run_op(16'h0001);
      check("sq_lsb_trunc", sq, 16'h0000);
      run_op(16'h3FFF);
      check("sq_max_no_ovf", sq, 16'hFFF8);
      check("ovf_max_no_ovf", ovf, 1'b0);
      run_op(16'h4000);
      check("sq_sat", sq, 16'hFFFF);
      check("ovf_sat", ovf, 1'b1);
      run_op(16'h0000);
      check("sq_zero", sq, 16'h0000);
      check("ovf_zero", ovf, 1'b0);

      // A start pulse mid-run must not disturb the operation in flight.
      @(negedge clk);
      start = 1'b1;
      x     = 16'h2000;
      exp_q.push_back(model(16'h2000));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      x     = 16'h1000;
      @(negedge clk);
      start = 1'b0;
      wait_valid(6, "latency_ignored_start");
      check("sq_ignored_start", sq, 16'h4000);
      run_op(16'h1000);
      check("sq_back_to_back", sq, 16'h1000);

      // Reset in the middle of a run discards it.
      @(negedge clk);
      start = 1'b1;
      x     = 16'h3000;
      exp_q.push_back(model(16'h3000));
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("midrun_rst_busy", busy, 1'b0);
      check("midrun_rst_valid", valid, 1'b0);
      check("midrun_rst_sq", sq, '0);
      check("midrun_rst_ovf", ovf, 1'b0);
      watch_no_valid("midrun_rst_no_valid");

      // Reset wins over a simultaneous start.
      run_op(16'h1800);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      x     = 16'h1000;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", busy, 1'b0);
      check("rst_start_valid", valid, 1'b0);
      check("rst_start_sq", sq, '0);
      watch_no_valid("rst_start_no_valid");

      repeat (100) run_op(W'($urandom));

      // Round trip: square a floor square root and its successor around each radicand.
      // Truncation of the successor's square can only guarantee >= rather than a strict excess.
      for (int n = 0; n < 200; n++) begin
         a = W'($urandom);
         r = isqrt(longint'(a) << F);
         run_op(W'(r));
         check_rel("roundtrip_low", sq, a, 1'b0);
         if (r + 1 <= longint'({W{1'b1}})) begin
            run_op(W'(r + 1));
            if (!ovf) check_rel("roundtrip_high", sq, a, 1'b1);
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
